// File: rtl/coin_field.sv
`default_nettype none
// ============================================================================
// Module   : coin_field
// Purpose  : Multi-slot coin spawner/collector for the grid snake game.
// Revision : 1.0 - initial release
// ============================================================================
module coin_field #(
    parameter int unsigned H           = 32,
    parameter int unsigned V           = 32,
    parameter int unsigned N_COINS     = 4,
    parameter int unsigned SPAWN_DELAY = 3,
    parameter int unsigned LIFETIME    = 64,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int unsigned SCORE_W     = 8,
    localparam int unsigned XW = (H > 1) ? $clog2(H) : 1,
    localparam int unsigned YW = (V > 1) ? $clog2(V) : 1,
    localparam int unsigned IW = (N_COINS > 1) ? $clog2(N_COINS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift_snake,
    input  logic [XW-1:0]      snake_head_x,
    input  logic [YW-1:0]      snake_head_y,
    output logic [XW-1:0]      cand_x,
    output logic [YW-1:0]      cand_y,
    input  logic               cand_occupied,
    input  logic [XW-1:0]      query_x,
    input  logic [YW-1:0]      query_y,
    output logic               query_hit,
    output logic [N_COINS-1:0] active,
    output logic               point,
    output logic [IW-1:0]      point_idx,
    output logic               expire,
    output logic [SCORE_W-1:0] score
);

    localparam int unsigned    AW         = (LIFETIME > 0) ? $clog2(LIFETIME + 1) : 1;
    localparam logic [AW-1:0]  AGE_LAST   = (LIFETIME > 0) ? AW'(LIFETIME - 1) : '0;
    localparam logic [15:0]    LFSR_INIT  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0]    LFSR_TAPS  = 16'hB400;
    localparam logic [3:0]     DELAY_LAST = 4'(SPAWN_DELAY);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_PROPOSE = 3'd2,
        S_CHECK   = 3'd3,
        S_PLACE   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [IW-1:0]      sel_q, sel_d;
    logic [3:0]         wait_q, wait_d;
    logic [XW-1:0]      cand_x_q, cand_x_d;
    logic [YW-1:0]      cand_y_q, cand_y_d;
    logic [N_COINS-1:0] active_q, active_d;
    logic [XW-1:0]      slot_x_q [N_COINS];
    logic [XW-1:0]      slot_x_d [N_COINS];
    logic [YW-1:0]      slot_y_q [N_COINS];
    logic [YW-1:0]      slot_y_d [N_COINS];
    logic [AW-1:0]      age_q [N_COINS];
    logic [AW-1:0]      age_d [N_COINS];
    logic               point_q, point_d;
    logic [IW-1:0]      point_idx_q, point_idx_d;
    logic               expire_q, expire_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               query_hit_q, query_hit_d;

    logic [N_COINS-1:0] collect_hit;
    logic [N_COINS-1:0] age_step;
    logic [N_COINS-1:0] expire_hit;
    logic [N_COINS-1:0] query_match;
    logic [N_COINS-1:0] cand_clash;
    logic               x_oob;
    logic               y_oob;
    logic               cand_reject;
    logic [IW-1:0]      free_idx;
    logic               place_en;
    logic [3:0]         wait_inc;

    for (genvar g = 0; g < int'(N_COINS); g++) begin : g_slot
        assign collect_hit[g] = active_q[g] && (slot_x_q[g] == snake_head_x)
                                            && (slot_y_q[g] == snake_head_y);
        assign age_step[g]    = (LIFETIME != 0) && shift_snake && active_q[g];
        assign expire_hit[g]  = age_step[g] && (age_q[g] == AGE_LAST);
        assign query_match[g] = active_q[g] && (slot_x_q[g] == query_x)
                                            && (slot_y_q[g] == query_y);
        assign cand_clash[g]  = active_q[g] && (slot_x_q[g] == cand_x_q)
                                            && (slot_y_q[g] == cand_y_q);
    end

    // A grid that fills its index space can never produce an out-of-range cell.
    if ((1 << XW) > H) begin : g_x_bound
        assign x_oob = (cand_x_q >= XW'(H));
    end else begin : g_x_full
        assign x_oob = 1'b0;
    end

    if ((1 << YW) > V) begin : g_y_bound
        assign y_oob = (cand_y_q >= YW'(V));
    end else begin : g_y_full
        assign y_oob = 1'b0;
    end

    assign cand_reject = cand_occupied || x_oob || y_oob || (|cand_clash)
                      || ((cand_x_q == snake_head_x) && (cand_y_q == snake_head_y));

    always_comb begin
        free_idx = '0;
        for (int i = int'(N_COINS) - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                free_idx = IW'(i);
            end
        end
    end

    assign lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    assign wait_inc = wait_q + 4'd1;

    // Spawn engine: one slot at a time, from selection through placement.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        wait_d   = wait_q;
        cand_x_d = cand_x_q;
        cand_y_d = cand_y_q;
        place_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!(&active_q)) begin
                    sel_d   = free_idx;
                    wait_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (shift_snake) begin
                    wait_d = wait_inc;
                    if (wait_inc == DELAY_LAST) begin
                        state_d = S_PROPOSE;
                    end
                end
            end
            S_PROPOSE: begin
                cand_x_d = lfsr_q[XW-1:0];
                cand_y_d = lfsr_q[XW+YW-1:XW];
                state_d  = S_CHECK;
            end
            S_CHECK: begin
                state_d = cand_reject ? S_PROPOSE : S_PLACE;
            end
            S_PLACE: begin
                place_en = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Collection has priority over expiry on the same slot.
    always_comb begin
        active_d    = active_q;
        slot_x_d    = slot_x_q;
        slot_y_d    = slot_y_q;
        age_d       = age_q;
        point_d     = 1'b0;
        point_idx_d = '0;
        expire_d    = 1'b0;
        for (int i = 0; i < int'(N_COINS); i++) begin
            if (collect_hit[i]) begin
                active_d[i] = 1'b0;
                point_d     = 1'b1;
                point_idx_d = IW'(i);
            end else if (expire_hit[i]) begin
                active_d[i] = 1'b0;
                expire_d    = 1'b1;
            end else if (age_step[i]) begin
                age_d[i] = age_q[i] + AW'(1);
            end
            if (place_en && (sel_q == IW'(i))) begin
                active_d[i] = 1'b1;
                slot_x_d[i] = cand_x_q;
                slot_y_d[i] = cand_y_q;
                age_d[i]    = '0;
            end
        end
    end

    assign score_d     = (point_d && (score_q != SCORE_MAX)) ? score_q + SCORE_W'(1) : score_q;
    assign query_hit_d = |query_match;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            lfsr_q      <= LFSR_INIT;
            sel_q       <= '0;
            wait_q      <= '0;
            cand_x_q    <= '0;
            cand_y_q    <= '0;
            active_q    <= '0;
            point_q     <= 1'b0;
            point_idx_q <= '0;
            expire_q    <= 1'b0;
            score_q     <= '0;
            query_hit_q <= 1'b0;
            for (int i = 0; i < int'(N_COINS); i++) begin
                slot_x_q[i] <= '0;
                slot_y_q[i] <= '0;
                age_q[i]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            sel_q       <= sel_d;
            wait_q      <= wait_d;
            cand_x_q    <= cand_x_d;
            cand_y_q    <= cand_y_d;
            active_q    <= active_d;
            point_q     <= point_d;
            point_idx_q <= point_idx_d;
            expire_q    <= expire_d;
            score_q     <= score_d;
            query_hit_q <= query_hit_d;
            slot_x_q    <= slot_x_d;
            slot_y_q    <= slot_y_d;
            age_q       <= age_d;
        end
    end

    assign cand_x    = cand_x_q;
    assign cand_y    = cand_y_q;
    assign query_hit = query_hit_q;
    assign active    = active_q;
    assign point     = point_q;
    assign point_idx = point_idx_q;
    assign expire    = expire_q;
    assign score     = score_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_field.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_field
// Purpose  : Self-checking bench for coin_field against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coin_field;

    localparam int N    = 4;
    localparam int SD   = 3;
    localparam int LT   = 64;
    localparam int SMAX = 3;
    localparam int XW   = 5;
    localparam int YW   = 5;

    logic           clk;
    logic           reset;
    logic           shift_snake;
    logic [XW-1:0]  hx;
    logic [YW-1:0]  hy;
    logic [XW-1:0]  cand_x;
    logic [YW-1:0]  cand_y;
    logic           occ;
    logic [XW-1:0]  qx;
    logic [YW-1:0]  qy;
    logic           query_hit;
    logic [N-1:0]   active;
    logic           point;
    logic [1:0]     point_idx;
    logic           expire;
    logic [1:0]     score;

    int checks   = 0;
    int failures = 0;

    coin_field #(
        .H(32), .V(32), .N_COINS(4), .SPAWN_DELAY(3), .LIFETIME(64),
        .SEED(16'hACE1), .SCORE_W(2)
    ) dut (
        .clk(clk), .reset(reset), .shift_snake(shift_snake),
        .snake_head_x(hx), .snake_head_y(hy),
        .cand_x(cand_x), .cand_y(cand_y), .cand_occupied(occ),
        .query_x(qx), .query_y(qy), .query_hit(query_hit),
        .active(active), .point(point), .point_idx(point_idx),
        .expire(expire), .score(score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: coins as plain integer records, spawn as a pending job.
    bit m_started = 1'b0;
    bit m_act [N];
    int m_x [N];
    int m_y [N];
    int m_age [N];
    int m_lfsr, m_sel, m_need, m_step, m_cx, m_cy, m_pidx, m_score;
    bit m_point, m_expire, m_qhit;

    always @(posedge clk) begin
        bit qh, rej, do_place;
        int free;
        m_started = 1'b1;
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_age[i] = 0;
            end
            m_sel = -1; m_need = 0; m_step = 0; m_cx = 0; m_cy = 0;
            m_point = 0; m_pidx = 0; m_expire = 0; m_score = 0; m_qhit = 0;
            m_lfsr = 'hACE1;
        end else begin
            qh = 0;
            for (int i = 0; i < N; i++)
                if (m_act[i] && m_x[i] == int'(qx) && m_y[i] == int'(qy)) qh = 1;
            rej = occ || (m_cx >= 32) || (m_cy >= 32)
                  || (m_cx == int'(hx) && m_cy == int'(hy));
            for (int i = 0; i < N; i++)
                if (m_act[i] && m_x[i] == m_cx && m_y[i] == m_cy) rej = 1;
            do_place = 0;
            if (m_sel < 0) begin
                free = -1;
                for (int i = N - 1; i >= 0; i--) if (!m_act[i]) free = i;
                if (free >= 0) begin m_sel = free; m_need = SD; m_step = 0; end
            end else begin
                case (m_step)
                    0: if (shift_snake) begin
                           m_need--;
                           if (m_need == 0) m_step = 1;
                       end
                    1: begin
                           m_cx = m_lfsr % 32;
                           m_cy = (m_lfsr / 32) % 32;
                           m_step = 2;
                       end
                    2: m_step = rej ? 1 : 3;
                    default: do_place = 1;
                endcase
            end
            m_point = 0; m_pidx = 0; m_expire = 0;
            for (int i = 0; i < N; i++) begin
                if (m_act[i]) begin
                    if (m_x[i] == int'(hx) && m_y[i] == int'(hy)) begin
                        m_act[i] = 0; m_point = 1; m_pidx = i;
                    end else if (shift_snake) begin
                        m_age[i]++;
                        if (m_age[i] == LT) begin m_act[i] = 0; m_expire = 1; end
                    end
                end
            end
            if (do_place) begin
                m_act[m_sel] = 1; m_x[m_sel] = m_cx; m_y[m_sel] = m_cy;
                m_age[m_sel] = 0; m_sel = -1;
            end
            if (m_point && m_score < SMAX) m_score++;
            m_qhit = qh;
            m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB400) : (m_lfsr / 2);
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] mv;
        if (m_started) begin
            for (int i = 0; i < N; i++) mv[i] = m_act[i];
            check("cmp_active", 32'(active), 32'(mv));
            check("cmp_point", 32'(point), 32'(m_point));
            check("cmp_point_idx", 32'(point_idx), m_pidx);
            check("cmp_expire", 32'(expire), 32'(m_expire));
            check("cmp_score", 32'(score), m_score);
            check("cmp_query_hit", 32'(query_hit), 32'(m_qhit));
            check("cmp_cand", {22'd0, cand_y, cand_x}, (m_cy * 32) + m_cx);
        end
    end

    // Renderer sweeps coin cells on odd cycles, an arbitrary cell otherwise.
    int qcnt = 0;
    always @(negedge clk) begin
        int k;
        qcnt++;
        k = (qcnt / 2) % N;
        if (qcnt % 2 == 1) begin
            qx = 5'(m_x[k]); qy = 5'(m_y[k]);
        end else begin
            qx = 5'(qcnt % 32); qy = 5'd7;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        shift_snake = 1'b1;
        @(negedge clk);
        shift_snake = 1'b0;
        cyc(2);
    endtask

    task automatic wait_active(input string nm, input logic [N-1:0] exp, input int bound);
        for (int c = 0; c < bound; c++) begin
            if (active == exp) break;
            @(negedge clk);
        end
        check(nm, 32'(active), 32'(exp));
    endtask

    task automatic collect(input int s, input int exp_score);
        hx = 5'(m_x[s]); hy = 5'(m_y[s]);
        @(negedge clk);
        hx = 5'd31; hy = 5'd31;
        check("col_point", 32'(point), 1);
        check("col_idx", 32'(point_idx), s);
        check("col_score", 32'(score), exp_score);
        check("col_cleared", 32'(active[s]), 0);
        @(negedge clk);
        check("col_point_once", 32'(point), 0);
        repeat (SD) pulse();
        wait_active("col_refill", 4'b1111, 10);
    endtask

    initial begin
        int order [4] = '{0, 1, 3, 2};
        int exp_sc [4] = '{2, 3, 3, 3};
        int tgt;
        bit done_tie, done_exp;
        reset = 1'b0; shift_snake = 1'b0; occ = 1'b0; hx = 5'd31; hy = 5'd31;
        cyc(2);
        check("rst_active", 32'(active), 0);
        check("rst_score", 32'(score), 0);
        check("rst_point", 32'(point), 0);
        check("rst_expire", 32'(expire), 0);
        check("rst_cand", {22'd0, cand_y, cand_x}, 0);
        check("rst_qhit", 32'(query_hit), 0);
        reset = 1'b1;
        cyc(1);

        repeat (SD) pulse();
        wait_active("first_place", 4'b0001, 6);

        cyc(1);
        occ = 1'b1;
        repeat (SD) pulse();
        cyc(22);
        check("occupied_hold", 32'(active), 32'(4'b0001));
        occ = 1'b0;
        wait_active("after_hold", 4'b0011, 20);

        cyc(1);
        repeat (SD) pulse();
        wait_active("fill_2", 4'b0111, 10);
        cyc(1);
        repeat (SD) pulse();
        wait_active("fill_3", 4'b1111, 10);

        collect(2, 1);
        for (int k = 0; k < 4; k++) collect(order[k], exp_sc[k]);
        check("score_saturated", 32'(score), 3);

        done_tie = 0; done_exp = 0;
        for (int p = 0; p < 200 && !done_exp; p++) begin
            tgt = -1;
            for (int i = 0; i < N; i++) if (m_act[i] && m_age[i] == LT - 1) tgt = i;
            shift_snake = 1'b1;
            if (tgt >= 0 && !done_tie) begin hx = 5'(m_x[tgt]); hy = 5'(m_y[tgt]); end
            @(negedge clk);
            shift_snake = 1'b0; hx = 5'd31; hy = 5'd31;
            if (tgt >= 0 && !done_tie) begin
                check("tie_point", 32'(point), 1);
                check("tie_expire", 32'(expire), 0);
                check("tie_idx", 32'(point_idx), tgt);
                done_tie = 1;
            end else if (tgt >= 0) begin
                check("expire_pulse", 32'(expire), 1);
                check("expire_cleared", 32'(active[tgt]), 0);
                @(negedge clk);
                check("expire_once", 32'(expire), 0);
                done_exp = 1;
            end
            @(negedge clk);
        end
        if (!done_tie) check("tie_timeout", 0, 1);
        if (!done_exp) check("expire_timeout", 0, 1);

        done_tie = 0;
        for (int c = 0; c < 120 && !done_tie; c++) begin
            if (m_sel >= 0 && m_step == 2) begin
                shift_snake = 1'b0; reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                check("mid_rst_active", 32'(active), 0);
                check("mid_rst_score", 32'(score), 0);
                check("mid_rst_cand", {22'd0, cand_y, cand_x}, 0);
                check("mid_rst_point", 32'(point), 0);
                check("mid_rst_qhit", 32'(query_hit), 0);
                cyc(6);
                check("mid_rst_idle", 32'(active), 0);
                done_tie = 1;
            end else begin
                shift_snake = (c % 3 == 0);
                @(negedge clk);
            end
        end
        shift_snake = 1'b0;
        if (!done_tie) check("check_state_timeout", 0, 1);

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/coin_field.md
Name: coin_field

Overview:
- Multi-coin successor to the single-coin spawner for the grid snake game.
- Manages N_COINS independent coin slots on an H x V grid. A single spawn engine places coins at pseudo-random free cells, rejecting cells occupied by the snake or by other coins.
- Detects collection by the snake head, expires stale coins, and keeps a saturating score.
- Sits between the snake body logic (shift/occupancy) and the VGA renderer (pixel query).

Parameters:
- H, 32, grid width in cells; XW = ceil(log2(H)).
- V, 32, grid height in cells; YW = ceil(log2(V)).
- N_COINS, 4, number of coin slots (1..8); IW = max(1, ceil(log2(N_COINS))).
- SPAWN_DELAY, 3, shift_snake pulses to wait before a free slot is filled (1..15).
- LIFETIME, 64, shift_snake pulses before an uncollected coin expires; 0 = never expires.
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 1.
- SCORE_W, 8, score counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- shift_snake  in  1  one-cycle pulse per snake step.
- snake_head_x  in  XW  head column.
- snake_head_y  in  YW  head row.
- cand_x  out  XW  spawn candidate column, driven to the snake body lookup.
- cand_y  out  YW  spawn candidate row.
- cand_occupied  in  1  snake body covers (cand_x, cand_y); valid in the same cycle as the candidate.
- query_x  in  XW  renderer cell column.
- query_y  in  YW  renderer cell row.
- query_hit  out  1  registered: an active coin sits at the queried cell.
- active  out  N_COINS  per-slot exists bitmap.
- point  out  1  one-cycle collect pulse.
- point_idx  out  IW  slot index collected; valid while point=1.
- expire  out  1  one-cycle pulse when a coin times out.
- score  out  SCORE_W  collected coins, saturating.

Behaviour:
- Reset: when reset=0 at a posedge, clear all slot active/age/x/y, the spawn FSM goes to IDLE, and the LFSR loads SEED. Outputs after reset: active=0, point=0, point_idx=0, expire=0, score=0, query_hit=0, cand_x=0, cand_y=0. Reset overrides every other event in the same cycle.
- LFSR: 16-bit Galois, taps 16,14,13,11. Advances every cycle when not in reset.
- Spawn FSM states:
  - IDLE: when any slot is inactive, select the lowest-index inactive slot, clear the wait counter, go to WAIT.
  - WAIT: count shift_snake pulses. When the count reaches SPAWN_DELAY, go to PROPOSE.
  - PROPOSE: latch cand_x = lfsr[XW-1:0] and cand_y = lfsr[XW+YW-1:XW]; go to CHECK.
  - CHECK, held one cycle: reject if cand_x>=H, cand_y>=V, cand_occupied=1, the candidate equals the head, or the candidate equals any active slot. On reject go to PROPOSE; on accept go to PLACE.
  - PLACE: write x/y into the selected slot, set active, clear age; go to IDLE.
  - No retry limit; the LFSR guarantees progress.
- The selected slot is fixed from IDLE until PLACE. Slots freed meanwhile wait their turn.
- Collection:
  - Checked every cycle. An active slot whose x/y equals the head is cleared next edge, with point=1 and point_idx=slot.
  - At most one match is possible, since coins never overlap.
  - score increments and holds at 2^SCORE_W-1.
- Expiry (LIFETIME>0):
  - On each shift_snake pulse, every active slot's age increments.
  - When age reaches LIFETIME the slot clears and expire pulses for one cycle. If several slots expire together, one pulse is emitted.
  - If collection and expiry hit the same slot in the same cycle, collection wins: point=1, expire=0 for that slot.
- query_hit: one-cycle latency; compares the query against all active slots as they are in the cycle of the query.
- Widths: all position compares use the full XW/YW. The age counter is ceil(log2(LIFETIME+1)) bits.

Test Plan:
- Reset with reset=0 for 2 cycles, then release; pulse shift_snake 3 times, keep cand_occupied=0 and the head at (31,31) -> active=4'b0001 within 3 cycles of the third pulse, slot 0 at a cell with x<32 and y<32.
- Hold cand_occupied=1 for 10 candidates, then 0 -> no placement during the hold; a placement follows the first unoccupied, in-range candidate.
- Fill all 4 slots, then drive the head onto slot 2's cell -> point=1 for exactly one cycle, point_idx=2, score 0->1, active[2]=0. Slot 2 refills after 3 more shift_snake pulses.
- With LIFETIME=64, no collection -> after the 64th shift_snake, expire pulses once and all slots placed together clear.
- Set SCORE_W=2 and collect 5 coins -> score saturates at 3.
- Collect on the same cycle age reaches LIFETIME; separately, assert reset=0 mid-CHECK -> first case gives point=1 and expire=0; second case gives all outputs at reset values the next cycle and the FSM in IDLE.
